// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for cpu_step_ctrl: controller state encoding, run-rate codes,
// default halt instruction and the prescaler terminal-count helper.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } ctrl_state_t;

  localparam logic [1:0] RATE_1HZ  = 2'd0;
  localparam logic [1:0] RATE_2HZ  = 2'd1;
  localparam logic [1:0] RATE_10HZ = 2'd2;
  localparam logic [1:0] RATE_FAST = 2'd3;

  localparam logic [31:0] HALT_INST_DEFAULT = 32'hFFFFFFFF;

  // Terminal count of the run prescaler; the divisor is floored at 2 so that
  // two run ticks are never closer than two clocks, even for tiny clk_hz.
  function automatic logic [31:0] rate_divisor(input int unsigned clk_hz,
                                               input logic [1:0] sel);
    int unsigned div;
    case (sel)
      RATE_1HZ:  div = clk_hz;
      RATE_2HZ:  div = clk_hz / 2;
      RATE_10HZ: div = clk_hz / 10;
      default:   div = 2;
    endcase
    if (div < 2) div = 2;
    return div - 1;
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_key_debounce.sv
// key_debounce: 2-flop synchronizer plus level debouncer for an active-low push button;
// emits a one-clock press pulse per accepted 1->0 transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             key_level;
  logic             armed;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (sync_2 != key_level) && (cnt == CNT_MAX);

  // Synchronizer flops reset to the pressed level while the debounced level resets
  // to released: a key held through reset is accepted silently and only arms the
  // press output once a genuine release has been seen.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      key_level <= 1'b1;
      armed     <= 1'b0;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      sync_1 <= key_n;
      sync_2 <= sync_1;
      press  <= accept && !sync_2 && armed;
      if (sync_2 != key_level) begin
        if (accept) begin
          key_level <= sync_2;
          cnt       <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
      if (key_level && sync_2) armed <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: run/single-step/halt controller producing one cpu_en pulse per instruction.
// Optional macro BREAKPOINT_EN adds the bp_addr/bp_valid ports and a PC breakpoint compare.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic [31:0] HALT_INST       = HALT_INST_DEFAULT
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        run_sw,
  input  logic        step_key_n,
  input  logic [1:0]  rate_sel,
  input  logic [7:0]  pc,
  input  logic [31:0] inst,
`ifdef BREAKPOINT_EN
  input  logic [7:0]  bp_addr,
  input  logic        bp_valid,
`endif
  output logic        cpu_en,
  output logic [1:0]  state,
  output logic        halted,
  output logic [15:0] instr_count
);

  ctrl_state_t state_q;
  ctrl_state_t state_d;
  logic        pulse_d;
  logic        press;
  logic [31:0] presc_q;
  logic [31:0] presc_tc;
  logic [1:0]  rate_q;
  logic        presc_clr;
  logic        tick;
  logic        halt_cond;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .key_n (step_key_n),
    .press (press)
  );

  assign presc_tc = rate_divisor(CLK_HZ, rate_sel);
  assign tick     = (presc_q == presc_tc) && (rate_sel == rate_q);

`ifdef BREAKPOINT_EN
  assign halt_cond = (inst == HALT_INST) || (bp_valid && (pc == bp_addr));
`else
  logic pc_unused;
  assign pc_unused = ^pc;
  assign halt_cond = (inst == HALT_INST);
`endif

  // The prescaler restarts on RUN entry and on any rate change so the first run
  // tick is always a full period away from the previous pulse.
  assign presc_clr = (rate_sel != rate_q) || ((state_q != ST_RUN) && (state_d == ST_RUN));

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      presc_q <= '0;
      rate_q  <= RATE_1HZ;
    end else begin
      rate_q <= rate_sel;
      if (presc_clr || tick) presc_q <= '0;
      else                   presc_q <= presc_q + 32'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_sw)     state_d = ST_RUN;
        else if (press) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (!run_sw) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (halt_cond) state_d = ST_HALT;
          else           pulse_d = 1'b1;
        end
      end
      ST_STEP: begin
        // Only the halt instruction stops a step; a breakpoint must be steppable.
        if (inst == HALT_INST) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_IDLE;
          pulse_d = 1'b1;
        end
      end
      ST_HALT: begin
        if (!run_sw)    state_d = ST_IDLE;
        else if (press) state_d = ST_STEP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q     <= ST_IDLE;
      cpu_en      <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      cpu_en  <= pulse_d;
      if (cpu_en) instr_count <= instr_count + 16'd1;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == ST_HALT);

endmodule
